// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2*WL-bit dividend over WL-bit divisor, one quotient bit per cycle.
// Divide-by-zero and quotient overflow are flagged on the accepting edge without entering CALC.
module seq_divider #(
  parameter int WL = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*WL-1:0]   dividend,
  input  logic [WL-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic [WL-1:0]     quotient,
  output logic [WL-1:0]     remainder,
  output logic              error
);

  localparam int CW = $clog2(WL + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WL - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WL:0]     rem_q;
  logic [WL-1:0]   quo_q;
  logic [WL-1:0]   dsr_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [WL-1:0]   quotient_q;
  logic [WL-1:0]   remainder_q;

  logic [WL+1:0]   shift_d;
  logic [WL+1:0]   diff_d;
  logic [WL:0]     rem_d;
  logic [WL-1:0]   quo_d;
  logic            start_err_d;

  // One restoring iteration on {R,Q}; the extra top bit of diff_d is the borrow.
  always_comb begin
    shift_d = {rem_q, quo_q[WL-1]};
    diff_d  = shift_d - {2'b00, dsr_q};
    if (diff_d[WL+1] == 1'b0) begin
      rem_d = diff_d[WL:0];
      quo_d = {quo_q[WL-2:0], 1'b1};
    end else begin
      rem_d = shift_d[WL:0];
      quo_d = {quo_q[WL-2:0], 1'b0};
    end
  end

  // A high half not below the divisor would need more than WL quotient bits.
  always_comb begin
    if ((divisor == {WL{1'b0}}) || (dividend[2*WL-1:WL] >= divisor)) begin
      start_err_d = 1'b1;
    end else begin
      start_err_d = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {(WL+1){1'b0}};
      quo_q       <= {WL{1'b0}};
      dsr_q       <= {WL{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      quotient_q  <= {WL{1'b0}};
      remainder_q <= {WL{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dsr_q <= divisor;
            if (start_err_d) begin
              done_q      <= 1'b1;
              error_q     <= 1'b1;
              quotient_q  <= {WL{1'b1}};
              remainder_q <= {WL{1'b0}};
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
              rem_q   <= {1'b0, dividend[2*WL-1:WL]};
              quo_q   <= dividend[WL-1:0];
              cnt_q   <= {CW{1'b0}};
            end
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == LAST_CNT) begin
            quotient_q  <= quo_d;
            remainder_q <= rem_d[WL-1:0];
            done_q      <= 1'b1;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
